issue_hazard_ctrl: RTL and testbench
====================================

Name: issue_hazard_ctrl

Overview:
- Decode-stage issue controller for the 5-stage RV32I pipeline.
- Takes the field-split instruction (opcode, rd, rs1, rs2) and classifies it by opcode. Tracks in-flight destination tags through EX/MEM/WB.
- Detects load-use and write-back hazards, inserts bubbles, generates registered forwarding selects for EX, and applies branch flush.
- Sits between the decode field splitter and the ID/EX pipeline register; its handshake controls the IF/ID register.

Parameters:
- RF_BYPASS, 1, 1 = register file is write-first (WB-stage match needs no action); 0 = a WB-stage match on a used source stalls decode 1 cycle.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_ready  out  1  controller accepts the decode instruction this cycle (combinational)
- id_opcode  in  7  instr[6:0]
- id_rd  in  5  instr[11:7]
- id_rs1  in  5  instr[19:15]
- id_rs2  in  5  instr[24:20]
- flush  in  1  branch/jump redirect resolved in EX this cycle
- ex_valid, ex_regwrite, ex_memread  out  1 each  EX-stage tag
- ex_rd  out  5  EX-stage destination
- fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 MEM-stage result, 10 WB-stage result
- ex_illegal  out  1  EX-stage instruction had an unrecognised opcode
- mem_valid, mem_regwrite  out  1 each; mem_rd  out  5
- wb_valid, wb_regwrite  out  1 each; wb_rd  out  5

Behaviour:
- Opcode classes (uses_rs1 / uses_rs2 / regwrite / memread):
  - LOAD 0000011 (1/0/1/1)
  - STORE 0100011 (1/1/0/0)
  - OP 0110011 (1/1/1/0)
  - OP-IMM 0010011 (1/0/1/0)
  - BRANCH 1100011 (1/1/0/0)
  - JALR 1100111 (1/0/1/0)
  - JAL 1101111 (0/0/1/0)
  - LUI 0110111, AUIPC 0010111 (0/0/1/0)
  - Any other opcode: all zero, illegal=1.
- regwrite is forced to 0 when id_rd==0. A source equal to x0 never matches.
- Load-use stall: ex_valid & ex_memread & ex_rd matches a used source.
- WB stall (RF_BYPASS=0 only): mem_valid & mem_regwrite & mem_rd matches a used source. mem_rd is the producer that will sit in WB while decode reads the register file next cycle; that check is done at issue.
- id_ready = flush | ~(load-use stall | WB stall). The combinational path uses current-cycle inputs only.
- accept = id_valid & id_ready & ~flush.
- Every clock edge, in order:
  - WB <- MEM.
  - MEM <- EX, with mem_valid = ex_valid.
  - EX <- decode tag if accept; otherwise EX <- bubble (all valid/regwrite/memread/illegal = 0, rd = 0, fwd = 00).
- Forwarding selects are registered at accept:
  - fwd_x = 01 if the current EX tag (valid, regwrite) matches rs_x.
  - Else fwd_x = 10 if the current MEM tag matches.
  - Else 00.
  - The youngest producer wins.
- Flush has priority over stall: the decode instruction is dropped (id_ready=1, EX <- bubble). The EX tag still advances to MEM, because the branch itself completes.
- Latency: accepted instruction appears on ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later.
- Stall holds for exactly 1 cycle per load-use; the upstream must hold its fields stable while id_ready=0.
- id_valid=0 inserts a bubble and does not affect hazard logic.
- Reset (async, any time, including mid-stall): all ex_/mem_/wb_ outputs, fwd_a, fwd_b and ex_illegal = 0; counters = 0. Outputs clear immediately on rst_n low. The first edge after release behaves as an empty pipeline.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt and flush_cnt, CNT_W each.
  - stall_cnt increments each cycle id_valid & ~id_ready.
  - flush_cnt increments each cycle id_valid & flush.
  - Both saturate at all-ones and clear on reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- LOAD rd=5, then OP rs1=5 rs2=6 on the next cycle:
  - id_ready=0 for exactly 1 cycle.
  - EX shows a bubble.
  - The OP issues next with fwd_a=10, fwd_b=00.
- OP rd=3, then OP rs1=3 rs2=3 back-to-back: no stall; the second has fwd_a=fwd_b=01.
- OP rd=0, then OP rs1=0: no stall, fwd_a=00, ex_regwrite=0 for the first.
- BRANCH in EX with flush=1 while decode holds OP rd=7:
  - Next cycle ex_valid=0; mem_valid=1 (branch advanced).
  - With flush and a load-use stall in the same cycle, id_ready=1.
- RF_BYPASS=0: OP rd=9, NOP-class bubble, OP rs2=9 → 1-cycle stall, then issue with fwd_b=00. With RF_BYPASS=1, no stall.
- Opcode 1111111 → ex_illegal=1, no regwrite.
- rst_n low during a stall clears all outputs immediately.
- With HAZARD_PERF_CNT_EN: 3 load-use pairs give stall_cnt=3.

Source files
------------

// File: rtl/issue_hazard_ctrl_if.sv
// Decode-to-issue handshake: instruction fields and valid from the field
// splitter, the branch flush, and the ready that gates the IF/ID register.
interface issue_hazard_ctrl_if;
    logic       id_valid;
    logic       id_ready;
    logic [6:0] id_opcode;
    logic [4:0] id_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       flush;

    modport master (
        output id_valid, id_opcode, id_rd, id_rs1, id_rs2, flush,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_opcode, id_rd, id_rs1, id_rs2, flush,
        output id_ready
    );
endinterface

// File: rtl/issue_hazard_ctrl.sv
// Decode-stage issue controller for a 5-stage RV32I pipeline: EX/MEM/WB tag tracking,
// load-use / WB stalls, registered forwarding selects, flush. Optional HAZARD_PERF_CNT_EN.
module issue_hazard_ctrl #(
    parameter int RF_BYPASS = 1
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W     = 32
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    issue_hazard_ctrl_if.slave  dec,
    output logic                ex_valid,
    output logic                ex_regwrite,
    output logic                ex_memread,
    output logic [4:0]          ex_rd,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                ex_illegal,
    output logic                mem_valid,
    output logic                mem_regwrite,
    output logic [4:0]          mem_rd,
    output logic                wb_valid,
    output logic                wb_regwrite,
    output logic [4:0]          wb_rd
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
`endif
);

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic regwrite;
        logic memread;
        logic illegal;
    } iclass_t;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       illegal;
        logic [4:0] rd;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
    } ex_tag_t;

    function automatic iclass_t classify(input logic [6:0] opc);
        case (opc)
            7'b0000011: return 5'b10110;  // LOAD
            7'b0100011: return 5'b11000;  // STORE
            7'b0110011: return 5'b11100;  // OP
            7'b0010011: return 5'b10100;  // OP-IMM
            7'b1100011: return 5'b11000;  // BRANCH
            7'b1100111: return 5'b10100;  // JALR
            7'b1101111,
            7'b0110111,
            7'b0010111: return 5'b00100;  // JAL, LUI, AUIPC
            default:    return 5'b00001;
        endcase
    endfunction

    // x0 is hard-wired, so it never creates a dependency.
    function automatic logic src_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used && (rs != 5'd0) && (rs == rd);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                           input logic ex_en, input logic [4:0] ex_rd_q,
                                           input logic mem_en, input logic [4:0] mem_rd_q);
        if (ex_en && src_hit(used, rs, ex_rd_q))
            return 2'b01;
        else if (mem_en && src_hit(used, rs, mem_rd_q))
            return 2'b10;
        else
            return 2'b00;
    endfunction

`ifdef HAZARD_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        if (en && (cnt != {CNT_W{1'b1}}))
            return cnt + 1'b1;
        else
            return cnt;
    endfunction
`endif

    iclass_t    cls;
    logic       id_regwrite;
    logic       load_use;
    logic       wb_stall;
    logic       ready;
    logic       accept;
    logic       ex_fwd_en;
    logic       mem_fwd_en;
    ex_tag_t    tag_n;

    logic       vld_p0;
    ex_tag_t    tag_p0;
    logic       vld_p1;
    logic       rw_p1;
    logic [4:0] rd_p1;
    logic       vld_p2;
    logic       rw_p2;
    logic [4:0] rd_p2;

    always_comb begin
        cls         = classify(dec.id_opcode);
        id_regwrite = cls.regwrite & (dec.id_rd != 5'd0);
        load_use    = vld_p0 & tag_p0.memread &
                      (src_hit(cls.uses_rs1, dec.id_rs1, tag_p0.rd) |
                       src_hit(cls.uses_rs2, dec.id_rs2, tag_p0.rd));
        // Without a write-first regfile, a producer now in MEM is still unwritten when decode reads next cycle.
        wb_stall    = (RF_BYPASS == 0) & vld_p1 & rw_p1 &
                      (src_hit(cls.uses_rs1, dec.id_rs1, rd_p1) |
                       src_hit(cls.uses_rs2, dec.id_rs2, rd_p1));
        ready       = dec.flush | ~(load_use | wb_stall);
        accept      = dec.id_valid & ready & ~dec.flush;
        ex_fwd_en   = vld_p0 & tag_p0.regwrite;
        mem_fwd_en  = vld_p1 & rw_p1;

        tag_n = '0;
        if (accept) begin
            tag_n.regwrite = id_regwrite;
            tag_n.memread  = cls.memread;
            tag_n.illegal  = cls.illegal;
            tag_n.rd       = dec.id_rd;
            tag_n.fwd_a    = fwd_sel(cls.uses_rs1, dec.id_rs1, ex_fwd_en, tag_p0.rd, mem_fwd_en, rd_p1);
            tag_n.fwd_b    = fwd_sel(cls.uses_rs2, dec.id_rs2, ex_fwd_en, tag_p0.rd, mem_fwd_en, rd_p1);
        end
    end

    assign dec.id_ready = ready;

    // p0 = EX, p1 = MEM, p2 = WB; a rejected or flushed decode slot enters EX as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            tag_p0 <= '0;
            vld_p1 <= 1'b0;
            rw_p1  <= 1'b0;
            rd_p1  <= 5'd0;
            vld_p2 <= 1'b0;
            rw_p2  <= 1'b0;
            rd_p2  <= 5'd0;
        end else begin
            vld_p2 <= vld_p1;
            rw_p2  <= rw_p1;
            rd_p2  <= rd_p1;
            vld_p1 <= vld_p0;
            rw_p1  <= tag_p0.regwrite;
            rd_p1  <= tag_p0.rd;
            vld_p0 <= accept;
            tag_p0 <= tag_n;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= sat_inc(stall_cnt, dec.id_valid & ~ready);
            flush_cnt <= sat_inc(flush_cnt, dec.id_valid & dec.flush);
        end
    end
`endif

    assign ex_valid     = vld_p0;
    assign ex_regwrite  = tag_p0.regwrite;
    assign ex_memread   = tag_p0.memread;
    assign ex_rd        = tag_p0.rd;
    assign fwd_a        = tag_p0.fwd_a;
    assign fwd_b        = tag_p0.fwd_b;
    assign ex_illegal   = tag_p0.illegal;
    assign mem_valid    = vld_p1;
    assign mem_regwrite = rw_p1;
    assign mem_rd       = rd_p1;
    assign wb_valid     = vld_p2;
    assign wb_regwrite  = rw_p2;
    assign wb_rd        = rd_p2;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Bench for issue_hazard_ctrl: two instances (RF_BYPASS=0 and 1) driven with the same
// decode stream, compared every cycle against an opcode-table/pipeline-array model.
module tb_issue_hazard_ctrl;

    localparam bit [6:0] OP_LOAD   = 7'b0000011;
    localparam bit [6:0] OP_OP     = 7'b0110011;
    localparam bit [6:0] OP_BRANCH = 7'b1100011;
    localparam bit [6:0] OP_BAD    = 7'b1111111;

    // {opcode, uses_rs1, uses_rs2, regwrite, memread}
    localparam bit [10:0] CTAB [10] = '{
        {7'b0000011, 4'b1011}, {7'b0100011, 4'b1100}, {7'b0110011, 4'b1110},
        {7'b0010011, 4'b1010}, {7'b1100011, 4'b1100}, {7'b1100111, 4'b1010},
        {7'b1101111, 4'b0010}, {7'b0110111, 4'b0010}, {7'b0010111, 4'b0010},
        {7'b0000011, 4'b1011}
    };
    localparam bit [6:0] ROPS [11] = '{
        7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1100111,
        7'b1101111, 7'b0110111, 7'b0010111, 7'b0000011, 7'b1111111
    };

    typedef struct packed {
        bit       v;
        bit       rw;
        bit       mr;
        bit       ill;
        bit [4:0] rd;
        bit [1:0] fa;
        bit [1:0] fb;
    } mtag_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    issue_hazard_ctrl_if if0 ();
    issue_hazard_ctrl_if if1 ();

    // {ex_valid, ex_regwrite, ex_memread, ex_rd, fwd_a, fwd_b, ex_illegal,
    //  mem_valid, mem_regwrite, mem_rd, wb_valid, wb_regwrite, wb_rd}
    wire [26:0] ov0;
    wire [26:0] ov1;

`ifdef HAZARD_PERF_CNT_EN
    localparam int CMAX = 15;
    wire [3:0] sc0, fc0, sc1, fc1;
    int m_stall [2];
    int m_flush [2];
`endif

    mtag_t m_ex  [2];
    mtag_t m_mem [2];
    mtag_t m_wb  [2];
    bit    dut_rdy [2];

    issue_hazard_ctrl #(
        .RF_BYPASS(0)
`ifdef HAZARD_PERF_CNT_EN
        , .CNT_W(4)
`endif
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .dec(if0),
        .ex_valid(ov0[26]), .ex_regwrite(ov0[25]), .ex_memread(ov0[24]), .ex_rd(ov0[23:19]),
        .fwd_a(ov0[18:17]), .fwd_b(ov0[16:15]), .ex_illegal(ov0[14]),
        .mem_valid(ov0[13]), .mem_regwrite(ov0[12]), .mem_rd(ov0[11:7]),
        .wb_valid(ov0[6]), .wb_regwrite(ov0[5]), .wb_rd(ov0[4:0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(sc0), .flush_cnt(fc0)
`endif
    );

    issue_hazard_ctrl #(
        .RF_BYPASS(1)
`ifdef HAZARD_PERF_CNT_EN
        , .CNT_W(4)
`endif
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .dec(if1),
        .ex_valid(ov1[26]), .ex_regwrite(ov1[25]), .ex_memread(ov1[24]), .ex_rd(ov1[23:19]),
        .fwd_a(ov1[18:17]), .fwd_b(ov1[16:15]), .ex_illegal(ov1[14]),
        .mem_valid(ov1[13]), .mem_regwrite(ov1[12]), .mem_rd(ov1[11:7]),
        .wb_valid(ov1[6]), .wb_regwrite(ov1[5]), .wb_rd(ov1[4:0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input bit [6:0] op, output bit u1, output bit u2,
                          output bit rw, output bit mr, output bit ill);
        u1 = 0; u2 = 0; rw = 0; mr = 0; ill = 1;
        for (int i = 0; i < 10; i++) begin
            if (CTAB[i][10:4] == op) begin
                {u1, u2, rw, mr} = CTAB[i][3:0];
                ill = 0;
            end
        end
    endtask

    function automatic bit hit(input bit used, input bit [4:0] rs, input bit [4:0] rd);
        return used && (rs != 0) && (rs == rd);
    endfunction

    function automatic bit [1:0] fsel(input bit used, input bit [4:0] rs, input int k);
        if (m_ex[k].v && m_ex[k].rw && hit(used, rs, m_ex[k].rd)) return 2'b01;
        if (m_mem[k].v && m_mem[k].rw && hit(used, rs, m_mem[k].rd)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit [26:0] expv(input int k);
        return {m_ex[k].v, m_ex[k].rw, m_ex[k].mr, m_ex[k].rd, m_ex[k].fa, m_ex[k].fb, m_ex[k].ill,
                m_mem[k].v, m_mem[k].rw, m_mem[k].rd, m_wb[k].v, m_wb[k].rw, m_wb[k].rd};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
`ifdef HAZARD_PERF_CNT_EN
            m_stall[k] = 0; m_flush[k] = 0;
`endif
        end
    endtask

    task automatic drive(input bit v, input bit [6:0] op, input bit [4:0] rd,
                         input bit [4:0] rs1, input bit [4:0] rs2, input bit fl);
        if0.id_valid = v; if0.id_opcode = op; if0.id_rd = rd;
        if0.id_rs1 = rs1; if0.id_rs2 = rs2; if0.flush = fl;
        if1.id_valid = v; if1.id_opcode = op; if1.id_rd = rd;
        if1.id_rs1 = rs1; if1.id_rs2 = rs2; if1.flush = fl;
    endtask

    task automatic step(input bit v, input bit [6:0] op, input bit [4:0] rd,
                        input bit [4:0] rs1, input bit [4:0] rs2, input bit fl);
        bit u1, u2, rw, mr, ill, ld, wbs, rdy, acc;
        mtag_t nt [2];
        drive(v, op, rd, rs1, rs2, fl);
        #1;
        lookup(op, u1, u2, rw, mr, ill);
        rw = rw && (rd != 0);
        for (int k = 0; k < 2; k++) begin
            ld  = m_ex[k].v && m_ex[k].mr && (hit(u1, rs1, m_ex[k].rd) || hit(u2, rs2, m_ex[k].rd));
            wbs = (k == 0) && m_mem[k].v && m_mem[k].rw &&
                  (hit(u1, rs1, m_mem[k].rd) || hit(u2, rs2, m_mem[k].rd));
            rdy = fl || !(ld || wbs);
            acc = v && rdy && !fl;
            nt[k] = '0;
            if (acc) begin
                nt[k].v = 1; nt[k].rw = rw; nt[k].mr = mr; nt[k].ill = ill; nt[k].rd = rd;
                nt[k].fa = fsel(u1, rs1, k);
                nt[k].fb = fsel(u2, rs2, k);
            end
`ifdef HAZARD_PERF_CNT_EN
            if (v && !rdy && m_stall[k] < CMAX) m_stall[k]++;
            if (v && fl && m_flush[k] < CMAX) m_flush[k]++;
`endif
            if (k == 0) chk("id_ready_b0", 32'(if0.id_ready), 32'(rdy));
            else        chk("id_ready_b1", 32'(if1.id_ready), 32'(rdy));
        end
        dut_rdy[0] = if0.id_ready;
        dut_rdy[1] = if1.id_ready;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = nt[k];
        end
        #1;
        chk("pipe_b0", 32'(ov0), 32'(expv(0)));
        chk("pipe_b1", 32'(ov1), 32'(expv(1)));
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt_b0", 32'(sc0), 32'(m_stall[0]));
        chk("flush_cnt_b0", 32'(fc0), 32'(m_flush[0]));
        chk("stall_cnt_b1", 32'(sc1), 32'(m_stall[1]));
        chk("flush_cnt_b1", 32'(fc1), 32'(m_flush[1]));
`endif
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) step(0, OP_OP, 0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        drive(0, OP_OP, 0, 0, 0, 0);
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_b0", 32'(ov0), 32'd0);
        chk("reset_b1", 32'(ov1), 32'd0);
        #5 rst_n = 1'b1;

        // load-use: one stall cycle, bubble in EX, then issue forwarding from WB path
        step(1, OP_LOAD, 5, 1, 0, 0);
        step(1, OP_OP, 10, 5, 6, 0);
        chk("lu_stall", 32'(dut_rdy[1]), 32'd0);
        chk("lu_bubble", 32'(ov1[26]), 32'd0);
        step(1, OP_OP, 10, 5, 6, 0);
        chk("lu_ready", 32'(dut_rdy[1]), 32'd1);
        chk("lu_fwd_a", 32'(ov1[18:17]), 32'd2);
        chk("lu_fwd_b", 32'(ov1[16:15]), 32'd0);
        step(1, OP_OP, 10, 5, 6, 0);

        // back-to-back ALU dependency forwards from MEM path
        step(1, OP_OP, 3, 1, 2, 0);
        step(1, OP_OP, 4, 3, 3, 0);
        chk("b2b_ready", 32'(dut_rdy[1]), 32'd1);
        chk("b2b_fwd", 32'({ov1[18:17], ov1[16:15]}), 32'b0101);

        // x0 destination and source
        step(1, OP_OP, 0, 1, 2, 0);
        chk("x0_regwrite", 32'(ov1[25]), 32'd0);
        step(1, OP_OP, 11, 0, 0, 0);
        chk("x0_fwd_a", 32'(ov1[18:17]), 32'd0);

        // flush drops decode, branch advances to MEM
        step(1, OP_BRANCH, 0, 1, 2, 0);
        step(1, OP_OP, 7, 1, 2, 1);
        chk("flush_ex_valid", 32'(ov1[26]), 32'd0);
        chk("flush_mem_valid", 32'(ov1[13]), 32'd1);

        // flush overrides a load-use stall
        step(1, OP_LOAD, 5, 1, 0, 0);
        step(1, OP_OP, 8, 5, 0, 1);
        chk("flush_lu_ready_b0", 32'(dut_rdy[0]), 32'd1);
        chk("flush_lu_ready_b1", 32'(dut_rdy[1]), 32'd1);

        // non-bypassed regfile: WB stall only in the RF_BYPASS=0 instance
        bubbles(3);
        step(1, OP_OP, 9, 1, 2, 0);
        bubbles(1);
        step(1, OP_OP, 12, 0, 9, 0);
        chk("wb_stall_b0", 32'(dut_rdy[0]), 32'd0);
        chk("wb_nostall_b1", 32'(dut_rdy[1]), 32'd1);
        step(1, OP_OP, 12, 0, 9, 0);
        chk("wb_issue_b0", 32'({ov0[26], ov0[16:15]}), 32'b100);

        // unrecognised opcode
        step(1, OP_BAD, 13, 1, 2, 0);
        chk("illegal", 32'({ov1[14], ov1[25]}), 32'b10);

        // asynchronous reset in the middle of a load-use stall
        step(1, OP_LOAD, 5, 1, 0, 0);
        drive(1, OP_OP, 6, 5, 0, 0);
        #1;
        chk("pre_rst_stall", 32'(if1.id_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_b0", 32'(ov0), 32'd0);
        chk("rst_mid_b1", 32'(ov1), 32'd0);
        model_reset();
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_cnt", 32'({sc0, fc0, sc1, fc1}), 32'd0);
`endif
        #2 rst_n = 1'b1;

`ifdef HAZARD_PERF_CNT_EN
        for (int p = 0; p < 3; p++) begin
            step(1, OP_LOAD, 5, 0, 0, 0);
            step(1, OP_OP, 6, 5, 0, 0);
            step(1, OP_OP, 6, 5, 0, 0);
            step(1, OP_OP, 6, 5, 0, 0);
        end
        chk("three_lu_stall_cnt", 32'(sc1), 32'd3);
`endif

        // randomized traffic with dense register reuse
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ROPS[$urandom % 11], 5'($urandom % 8),
                 5'($urandom % 8), 5'($urandom % 8), ($urandom % 8) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
